// File: rtl/router_output_allocator.sv
// Per-output-port switch allocator: round-robin arbitration among input
// buffers, wormhole locking from head to tail flit, and downstream credit
// tracking so flits only leave when the neighbour has room.
module router_output_allocator #(
  parameter int unsigned NUM_INPUTS        = 5,
  parameter int unsigned FLIT_BUFFER_DEPTH = 8,
  parameter int unsigned IDX_W             = $clog2(NUM_INPUTS),
  parameter int unsigned CNT_W             = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc,
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [NUM_INPUTS-1:0] is_tail,
  input  logic [NUM_INPUTS-1:0] turn_disable,
  input  logic                  credit_in,
  output logic [NUM_INPUTS-1:0] grant,
  output logic                  send_out,
  output logic [IDX_W-1:0]      send_idx,
  output logic [CNT_W-1:0]      credit_count,
  output logic                  locked,
  output logic                  credit_err
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  localparam logic [CNT_W-1:0] FullCredits = CNT_W'(FLIT_BUFFER_DEPTH);
  localparam logic [IDX_W-1:0] LastIdx     = IDX_W'(NUM_INPUTS - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]        credit_q, credit_d;
  logic                    send_out_q, send_out_d;
  logic [IDX_W-1:0]        send_idx_q, send_idx_d;
  logic                    credit_err_q, credit_err_d;

  logic [NUM_INPUTS-1:0]   eligible;
  logic [NUM_INPUTS-1:0]   gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    gnt_any;
  logic                    found;
  int unsigned             cand;

  assign eligible = req & ~turn_disable;

  // Arbitration: owner-only while locked, round-robin from rr_ptr when idle.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    // Grants are suppressed during reset and whenever the neighbour is full.
    if (!rst_noc && (credit_q != '0)) begin
      if (state_q == StLocked) begin
        if (req[owner_q]) begin
          gnt[owner_q] = 1'b1;
          gnt_idx      = owner_q;
        end
      end else begin
        for (int unsigned off = 0; off < NUM_INPUTS; off++) begin
          cand = (32'(rr_ptr_q) + off) % NUM_INPUTS;
          if (!found && eligible[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = IDX_W'(cand);
          end
        end
      end
    end
  end

  assign gnt_any = |gnt;

  // Next-state: lock tracking, pointer rotation, credits and send register.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    send_out_d   = gnt_any;
    send_idx_d   = gnt_any ? gnt_idx : send_idx_q;

    if (gnt_any) begin
      if (state_q == StIdle) begin
        rr_ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
        // A head flit that is not also a tail claims the port.
        if (!is_tail[gnt_idx]) begin
          state_d = StLocked;
          owner_d = gnt_idx;
        end
      end else if (is_tail[owner_q]) begin
        state_d = StIdle;
      end
    end

    unique case ({gnt_any, credit_in})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        // A return with the counter already full means upstream bookkeeping broke.
        if (credit_q == FullCredits) begin
          credit_err_d = 1'b1;
        end else begin
          credit_d = credit_q + 1'b1;
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      credit_q     <= FullCredits;
      send_out_q   <= 1'b0;
      send_idx_q   <= '0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      credit_q     <= credit_d;
      send_out_q   <= send_out_d;
      send_idx_q   <= send_idx_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign grant        = gnt;
  assign send_out     = send_out_q;
  assign send_idx     = send_idx_q;
  assign credit_count = credit_q;
  assign locked       = (state_q == StLocked);
  assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_router_output_allocator.sv
// Directed bench for router_output_allocator with hand-computed expectations.
module tb_router_output_allocator;

  logic       clk_noc;
  logic       rst_noc;
  logic [4:0] req;
  logic [4:0] is_tail;
  logic [4:0] turn_disable;
  logic       credit_in;
  logic [4:0] grant;
  logic       send_out;
  logic [2:0] send_idx;
  logic [3:0] credit_count;
  logic       locked;
  logic       credit_err;

  int unsigned total;
  int unsigned bad;

  router_output_allocator #(
    .NUM_INPUTS       (5),
    .FLIT_BUFFER_DEPTH(8)
  ) dut (
    .clk_noc     (clk_noc),
    .rst_noc     (rst_noc),
    .req         (req),
    .is_tail     (is_tail),
    .turn_disable(turn_disable),
    .credit_in   (credit_in),
    .grant       (grant),
    .send_out    (send_out),
    .send_idx    (send_idx),
    .credit_count(credit_count),
    .locked      (locked),
    .credit_err  (credit_err)
  );

  initial clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive inputs 1 time unit after a rising edge, then let them settle.
  task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic [4:0] td,
                       input logic ci);
    req          = r;
    is_tail      = t;
    turn_disable = td;
    credit_in    = ci;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  logic [4:0] rr_exp [6];

  initial begin
    total = 0;
    bad   = 0;
    rst_noc = 1'b1;
    drive(5'b11111, 5'b11111, 5'b00000, 1'b0);
    chk("rst_grant", 32'(grant), 32'h0);
    tick();
    tick();
    chk("rst_send_out", 32'(send_out), 32'h0);
    chk("rst_send_idx", 32'(send_idx), 32'h0);
    chk("rst_credit", 32'(credit_count), 32'd8);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_err", 32'(credit_err), 32'h0);
    rst_noc = 1'b0;
    drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
    tick();

    // Single-flit packet from input 2.
    drive(5'b00100, 5'b00100, 5'b00000, 1'b0);
    chk("sf_grant", 32'(grant), 32'b00100);
    tick();
    chk("sf_send_out", 32'(send_out), 32'h1);
    chk("sf_send_idx", 32'(send_idx), 32'd2);
    chk("sf_credit", 32'(credit_count), 32'd7);
    chk("sf_locked", 32'(locked), 32'h0);
    drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
    tick();
    chk("sf_refill", 32'(credit_count), 32'd8);
    chk("sf_idle_send", 32'(send_out), 32'h0);
    chk("sf_idx_held", 32'(send_idx), 32'd2);

    // Round-robin with pointer at 3: inputs {0,1,4} served as 4,0,1,4,0.
    rr_exp[0] = 5'b10000;
    rr_exp[1] = 5'b00001;
    rr_exp[2] = 5'b00010;
    rr_exp[3] = 5'b10000;
    rr_exp[4] = 5'b00001;
    for (int i = 0; i < 5; i++) begin
      drive(5'b10011, 5'b11111, 5'b00000, 1'b1);
      chk("rr_grant", 32'(grant), 32'(rr_exp[i]));
      tick();
      chk("rr_credit", 32'(credit_count), 32'd8);
      chk("rr_locked", 32'(locked), 32'h0);
    end

    // Wormhole: input 1 sends 4 flits while input 3 waits (pointer now 1).
    for (int i = 0; i < 4; i++) begin
      drive(5'b01010, (i == 3) ? 5'b01010 : 5'b01000, 5'b00000, 1'b0);
      chk("wh_grant", 32'(grant), 32'b00010);
      tick();
      chk("wh_locked", 32'(locked), (i == 3) ? 32'h0 : 32'h1);
      chk("wh_send_idx", 32'(send_idx), 32'd1);
    end
    drive(5'b01000, 5'b01000, 5'b00000, 1'b0);
    chk("wh_next_grant", 32'(grant), 32'b01000);
    tick();
    chk("wh_credit", 32'(credit_count), 32'd3);
    chk("wh_send_idx3", 32'(send_idx), 32'd3);
    for (int i = 0; i < 5; i++) begin
      drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
      tick();
    end
    chk("wh_refill", 32'(credit_count), 32'd8);

    // Credit exhaustion: 10-flit packet from input 0, no returns.
    for (int i = 0; i < 10; i++) begin
      drive(5'b00001, 5'b00000, 5'b00000, 1'b0);
      chk("ce_grant", 32'(grant), (i < 8) ? 32'b00001 : 32'h0);
      tick();
    end
    chk("ce_credit0", 32'(credit_count), 32'd0);
    chk("ce_locked", 32'(locked), 32'h1);
    drive(5'b00001, 5'b00000, 5'b00000, 1'b1);
    chk("ce_pulse_grant", 32'(grant), 32'h0);
    tick();
    chk("ce_credit1", 32'(credit_count), 32'd1);
    drive(5'b00001, 5'b00000, 5'b00000, 1'b0);
    chk("ce_extra_grant", 32'(grant), 32'b00001);
    tick();
    chk("ce_credit_back0", 32'(credit_count), 32'd0);
    drive(5'b00001, 5'b00001, 5'b00000, 1'b1);
    chk("ce_blocked", 32'(grant), 32'h0);
    tick();
    drive(5'b00001, 5'b00001, 5'b00000, 1'b0);
    chk("ce_tail_grant", 32'(grant), 32'b00001);
    tick();
    chk("ce_unlocked", 32'(locked), 32'h0);
    chk("ce_credit_end", 32'(credit_count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
      tick();
    end
    chk("ce_refill", 32'(credit_count), 32'd8);
    chk("ce_no_err", 32'(credit_err), 32'h0);

    // Turn disable blocks input 4; a return at full credits is an error.
    drive(5'b10000, 5'b10000, 5'b10000, 1'b1);
    chk("td_grant", 32'(grant), 32'h0);
    tick();
    chk("td_credit_sat", 32'(credit_count), 32'd8);
    chk("td_err", 32'(credit_err), 32'h1);
    drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
    tick();
    chk("td_err_sticky", 32'(credit_err), 32'h1);

    // Reset mid-packet: input 2 holds the port with 3 credits left (pointer 1).
    for (int i = 0; i < 5; i++) begin
      drive(5'b00100, 5'b00000, 5'b00000, 1'b0);
      chk("rm_grant", 32'(grant), 32'b00100);
      tick();
    end
    chk("rm_credit3", 32'(credit_count), 32'd3);
    chk("rm_locked", 32'(locked), 32'h1);
    chk("rm_send_out", 32'(send_out), 32'h1);
    #2;
    rst_noc = 1'b1;
    #1;
    chk("rm_async_locked", 32'(locked), 32'h0);
    chk("rm_async_credit", 32'(credit_count), 32'd8);
    chk("rm_async_send", 32'(send_out), 32'h0);
    chk("rm_async_grant", 32'(grant), 32'h0);
    chk("rm_async_err", 32'(credit_err), 32'h0);
    tick();
    rst_noc = 1'b0;
    drive(5'b11111, 5'b11111, 5'b00000, 1'b0);
    chk("rm_first_arb", 32'(grant), 32'b00001);
    tick();
    drive(5'b11111, 5'b11111, 5'b00000, 1'b0);
    chk("rm_second_arb", 32'(grant), 32'b00010);
    tick();
    chk("rm_credit_after", 32'(credit_count), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
